// File: rtl/eprisc_bus_pkg.sv
// Shared definitions for the epRISC I/O controller byte bus.
// Holds the frame phase encoding (common with the controller), the idle and
// controller-reset addresses, the request word field positions, the master
// FSM state type and a phase-advance helper.
package eprisc_bus_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BYTE_W  = 8;

    // Frame phases, identical to the controller's encoding
    localparam logic [PHASE_W-1:0] PH_LOAD  = 3'd1;
    localparam logic [PHASE_W-1:0] PH_LOLO  = 3'd2;
    localparam logic [PHASE_W-1:0] PH_LO    = 3'd3;
    localparam logic [PHASE_W-1:0] PH_HI    = 3'd4;
    localparam logic [PHASE_W-1:0] PH_HIHI  = 3'd5;
    localparam logic [PHASE_W-1:0] PH_REG   = 3'd6;
    localparam logic [PHASE_W-1:0] PH_STORE = 3'd7;

    // Request word layout {write, addr, data}
    localparam int unsigned WR_BIT   = 31;
    localparam int unsigned ADDR_MSB = 30;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 0;

    // 0x7FFF is unmapped for reads (a write there resets the controller)
    localparam logic [ADDR_W-1:0] RESET_ADDR = 15'h7FFF;
    localparam logic [WORD_W-1:0] IDLE_WORD  = {1'b0, RESET_ADDR, 16'h0000};

    typedef enum logic {
        ST_HOLD,
        ST_RUN
    } bus_state_e;

    // Load -> LoLo -> ... -> Store -> Load
    function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] ph);
        return (ph == PH_STORE) ? PH_LOAD : PHASE_W'(ph + 3'd1);
    endfunction

endpackage

// File: rtl/eprisc_bus_clkgen.sv
// Bus clock divider: toggles the bus clock every CLK_DIV iClk cycles.
// Ports: iClk, wInternalReset (async, active-high),
//        bus_clk_o (registered bus clock),
//        rise_o_c / fall_o_c (combinational strobes, high in the iClk cycle
//        whose closing edge makes the bus clock rise / fall).
module eprisc_bus_clkgen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic iClk,
    input  logic wInternalReset,
    output logic bus_clk_o,
    output logic rise_o_c,
    output logic fall_o_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             term_c;

    // Half-period counter and toggle
    always_comb begin
        term_c = (32'(cnt_q) == CLK_DIV - 32'd1);
        cnt_d  = term_c ? '0 : cnt_q + CNT_W'(1);
        clk_d  = term_c ? ~clk_q : clk_q;
    end

    always_ff @(posedge iClk or posedge wInternalReset) begin
        if (wInternalReset) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign bus_clk_o = clk_q;
    assign rise_o_c  = term_c & ~clk_q;
    assign fall_o_c  = term_c &  clk_q;

endmodule

// File: rtl/eprisc_bus_master.sv
// Host-side initiator for the epRISC I/O controller byte bus.
// Serializes {write, addr[14:0], data[15:0]} request words over a 7-phase
// frame on an 8-bit MOSI lane, collects 16-bit read data from MISO one frame
// later, and synchronizes the controller interrupt.
// Ports: iClk/wInternalReset; request side iReqValid/oReqReady/iReqWrite/
//        iReqAddr/iReqData; response side oRspValid/oRspAddr/oRspData;
//        oInterrupt; bus side oBusClock/oBusSelect/oBusMOSI/iBusMISO/
//        iBusInterrupt.
module eprisc_bus_master
    import eprisc_bus_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter logic [1:0]  SELECT   = 2'b01,
    parameter int unsigned RST_HOLD = 2
) (
    input  logic              iClk,
    input  logic              wInternalReset,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic              iReqWrite,
    input  logic [ADDR_W-1:0] iReqAddr,
    input  logic [DATA_W-1:0] iReqData,
    output logic              oRspValid,
    output logic [ADDR_W-1:0] oRspAddr,
    output logic [DATA_W-1:0] oRspData,
    output logic              oInterrupt,
    output logic              oBusClock,
    output logic [1:0]        oBusSelect,
    output logic [BYTE_W-1:0] oBusMOSI,
    input  logic [BYTE_W-1:0] iBusMISO,
    input  logic              iBusInterrupt
);

    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    logic rise_c, fall_c;

    bus_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [1:0]        sel_q, sel_d;
    logic [BYTE_W-1:0] mosi_q, mosi_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              cur_real_q, cur_real_d;
    logic              prev_read_q, prev_read_d;
    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
    logic              pend_q, pend_d;
    logic [WORD_W-1:0] pend_word_q, pend_word_d;
    logic              rdy_q, rdy_d;
    logic [BYTE_W-1:0] rsp_lo_q, rsp_lo_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              int_meta_q, int_q;

    eprisc_bus_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .iClk          (iClk),
        .wInternalReset(wInternalReset),
        .bus_clk_o     (oBusClock),
        .rise_o_c      (rise_c),
        .fall_o_c      (fall_c)
    );

    // Startup hold, frame sequencing, MOSI/MISO handling and request slot
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        phase_d     = phase_q;
        sel_d       = sel_q;
        mosi_d      = mosi_q;
        word_d      = word_q;
        cur_real_d  = cur_real_q;
        prev_read_d = prev_read_q;
        prev_addr_d = prev_addr_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_valid_d = 1'b0;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_HOLD: begin
                // Select goes active on the fall that ends the last hold period
                if (fall_c) begin
                    if (32'(hold_cnt_q) + 32'd1 >= RST_HOLD) begin
                        state_d = ST_RUN;
                        sel_d   = SELECT;
                        phase_d = PH_LOAD;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (rise_c) begin
                    phase_d = next_phase(phase_q);
                    mosi_d  = '0;
                    case (phase_d)
                        PH_LOLO: begin
                            // The outgoing frame becomes "previous": its read data arrives now
                            prev_read_d = cur_real_q & ~word_q[WR_BIT];
                            prev_addr_d = word_q[ADDR_MSB:ADDR_LSB];
                            word_d      = pend_q ? pend_word_q : IDLE_WORD;
                            cur_real_d  = pend_q;
                            pend_d      = 1'b0;
                            mosi_d      = word_d[7:0];
                        end
                        PH_LO:   mosi_d = word_q[15:8];
                        PH_HI:   mosi_d = word_q[23:16];
                        PH_HIHI: mosi_d = word_q[31:24];
                        default: mosi_d = '0;
                    endcase
                end
                if (fall_c) begin
                    if (phase_q == PH_LOLO) begin
                        rsp_lo_d = iBusMISO;
                    end
                    if (phase_q == PH_LO && prev_read_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_addr_d  = prev_addr_q;
                        rsp_data_d  = {iBusMISO, rsp_lo_q};
                    end
                end
            end
        endcase

        // Slot can only accept while empty, so it never collides with a take
        if (iReqValid && !pend_q) begin
            pend_d                          = 1'b1;
            pend_word_d[WR_BIT]             = iReqWrite;
            pend_word_d[ADDR_MSB:ADDR_LSB]  = iReqAddr;
            pend_word_d[DATA_MSB:DATA_LSB]  = iReqWrite ? iReqData : '0;
        end
        rdy_d = ~pend_d;
    end

    always_ff @(posedge iClk or posedge wInternalReset) begin
        if (wInternalReset) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            phase_q     <= PH_LOAD;
            sel_q       <= 2'b00;
            mosi_q      <= '0;
            word_q      <= IDLE_WORD;
            cur_real_q  <= 1'b0;
            prev_read_q <= 1'b0;
            prev_addr_q <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            rdy_q       <= 1'b1;
            rsp_lo_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            phase_q     <= phase_d;
            sel_q       <= sel_d;
            mosi_q      <= mosi_d;
            word_q      <= word_d;
            cur_real_q  <= cur_real_d;
            prev_read_q <= prev_read_d;
            prev_addr_q <= prev_addr_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            rdy_q       <= rdy_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Two-flop interrupt synchronizer
    always_ff @(posedge iClk or posedge wInternalReset) begin
        if (wInternalReset) begin
            int_meta_q <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            int_meta_q <= iBusInterrupt;
            int_q      <= int_meta_q;
        end
    end

    assign oReqReady  = rdy_q;
    assign oRspValid  = rsp_valid_q;
    assign oRspAddr   = rsp_addr_q;
    assign oRspData   = rsp_data_q;
    assign oInterrupt = int_q;
    assign oBusSelect = sel_q;
    assign oBusMOSI   = mosi_q;

endmodule

// File: tb/tb_eprisc_bus_master.sv
// Directed bench for eprisc_bus_master with a behavioural controller model.
`timescale 1ns/1ps
module tb_eprisc_bus_master;

    logic        iClk = 1'b0;
    logic        wInternalReset = 1'b1;
    logic        iReqValid = 1'b0;
    logic        oReqReady;
    logic        iReqWrite = 1'b0;
    logic [14:0] iReqAddr = '0;
    logic [15:0] iReqData = '0;
    logic        oRspValid;
    logic [14:0] oRspAddr;
    logic [15:0] oRspData;
    logic        oInterrupt;
    logic        oBusClock;
    logic [1:0]  oBusSelect;
    logic [7:0]  oBusMOSI;
    logic [7:0]  iBusMISO = 8'h00;
    logic        iBusInterrupt = 1'b0;

    always #5 iClk = ~iClk;

    eprisc_bus_master #(
        .CLK_DIV (2),
        .SELECT  (2'b01),
        .RST_HOLD(2)
    ) dut (
        .iClk          (iClk),
        .wInternalReset(wInternalReset),
        .iReqValid     (iReqValid),
        .oReqReady     (oReqReady),
        .iReqWrite     (iReqWrite),
        .iReqAddr      (iReqAddr),
        .iReqData      (iReqData),
        .oRspValid     (oRspValid),
        .oRspAddr      (oRspAddr),
        .oRspData      (oRspData),
        .oInterrupt    (oInterrupt),
        .oBusClock     (oBusClock),
        .oBusSelect    (oBusSelect),
        .oBusMOSI      (oBusMOSI),
        .iBusMISO      (iBusMISO),
        .iBusInterrupt (iBusInterrupt)
    );

    localparam logic [31:0] IDLE = 32'h7FFF_0000;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
        int unsigned cyc;
    } rsp_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [31:0] frames[$];
    rsp_t        rsps[$];

    // Controller model state
    logic [15:0] mem [0:127];
    int          sph = 1;
    logic [31:0] sh = '0;
    logic [15:0] rdata = '0;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (oRspValid) rsps.push_back('{oRspAddr, oRspData, cyc});
    end

    // Controller: phase advances on bus-clock rise; select 00 holds it in reset
    always @(posedge oBusClock) begin
        if (oBusSelect == 2'b00 || wInternalReset) begin
            sph      = 1;
            rdata    = '0;
            iBusMISO = 8'h00;
        end else begin
            sph = (sph == 7) ? 1 : sph + 1;
            case (sph)
                2:       iBusMISO = rdata[7:0];
                3:       iBusMISO = rdata[15:8];
                4, 5:    iBusMISO = 8'hA5;
                default: iBusMISO = 8'h00;
            endcase
        end
    end

    // Controller samples MOSI on the fall; executes the word after HiHi
    always @(negedge oBusClock) begin
        if (oBusSelect != 2'b00 && !wInternalReset) begin
            case (sph)
                2: sh[7:0]   = oBusMOSI;
                3: sh[15:8]  = oBusMOSI;
                4: sh[23:16] = oBusMOSI;
                5: begin
                    sh[31:24] = oBusMOSI;
                    frames.push_back(sh);
                    if (sh[31]) begin
                        mem[sh[22:16]] = sh[15:0];
                        rdata = '0;
                    end else begin
                        rdata = mem[sh[22:16]];
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] frame_at(input int i);
        return (i >= 0 && i < frames.size()) ? frames[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic rsp_t rsp_at(input int i);
        rsp_t r;
        r = '{15'h0, 16'h0, 0};
        if (i >= 0 && i < rsps.size()) r = rsps[i];
        return r;
    endfunction

    function automatic int find_frame(input logic [31:0] w);
        for (int i = 0; i < frames.size(); i++) if (frames[i] == w) return i;
        return -1;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance
    task automatic send_req(input logic wr, input logic [14:0] addr, input logic [15:0] data);
        int n;
        n = 0;
        iReqValid = 1'b1;
        iReqWrite = wr;
        iReqAddr  = addr;
        iReqData  = data;
        while (!oReqReady && n < 200) begin
            @(negedge iClk);
            n++;
        end
        check("req_ready_wait", 32'(n < 200), 32'd1);
        @(negedge iClk);
        iReqValid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k;
        k = 0;
        while (frames.size() < n && k < 2000) begin
            @(negedge iClk);
            k++;
        end
        check(tag, 32'(frames.size() >= n), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   idx;
        rsp_t r;

        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[7'h41] = 16'h1234;
        mem[7'h42] = 16'h5678;
        mem[7'h43] = 16'h9ABC;

        // Reset values
        repeat (3) @(negedge iClk);
        check("rst_busclk", 32'(oBusClock), 32'd0);
        check("rst_select", 32'(oBusSelect), 32'd0);
        check("rst_mosi", 32'(oBusMOSI), 32'd0);
        check("rst_ready", 32'(oReqReady), 32'd1);
        check("rst_rspvalid", 32'(oRspValid), 32'd0);
        check("rst_rspaddr", 32'(oRspAddr), 32'd0);
        check("rst_rspdata", 32'(oRspData), 32'd0);
        check("rst_int", 32'(oInterrupt), 32'd0);

        // Startup: select held 00 for 2 bus periods = 8 iClk
        wInternalReset = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge iClk);
            #1;
            n++;
            if (oBusSelect != 2'b00) break;
        end
        check("hold_cycles", 32'(n), 32'd8);
        check("select_on", 32'(oBusSelect), 32'd1);
        wait_frames(1, "first_frame_timeout");
        check("first_frame_idle", frame_at(0), IDLE);

        // Write 0x0012 <= 0xBEEF
        @(negedge iClk);
        frames.delete();
        rsps.delete();
        send_req(1'b1, 15'h0012, 16'hBEEF);
        wait_frames(3, "wr_timeout");
        check("wr_frame_seen", 32'(find_frame(32'h8012_BEEF) >= 0), 32'd1);
        check("wr_mem", 32'(mem[7'h12]), 32'h0000_BEEF);
        check("wr_no_rsp", 32'(rsps.size()), 32'd0);

        // Read 0x0041, answered during the following idle frame
        frames.delete();
        rsps.delete();
        send_req(1'b0, 15'h0041, 16'h0000);
        wait_frames(4, "rd_timeout");
        idx = find_frame(32'h0041_0000);
        check("rd_frame_seen", 32'(idx >= 0), 32'd1);
        check("rd_next_idle", frame_at(idx + 1), IDLE);
        check("rd_rsp_count", 32'(rsps.size()), 32'd1);
        r = rsp_at(0);
        check("rd_rsp_addr", 32'(r.addr), 32'h41);
        check("rd_rsp_data", 32'(r.data), 32'h1234);

        // Back-to-back reads fill consecutive frames
        frames.delete();
        rsps.delete();
        send_req(1'b0, 15'h0041, 16'h0000);
        send_req(1'b0, 15'h0042, 16'h0000);
        send_req(1'b0, 15'h0043, 16'h0000);
        wait_frames(6, "b2b_timeout");
        idx = find_frame(32'h0041_0000);
        check("b2b_first_seen", 32'(idx >= 0), 32'd1);
        check("b2b_frame2", frame_at(idx + 1), 32'h0042_0000);
        check("b2b_frame3", frame_at(idx + 2), 32'h0043_0000);
        check("b2b_rsp_count", 32'(rsps.size()), 32'd3);
        check("b2b_addr0", 32'(rsp_at(0).addr), 32'h41);
        check("b2b_data0", 32'(rsp_at(0).data), 32'h1234);
        check("b2b_addr1", 32'(rsp_at(1).addr), 32'h42);
        check("b2b_data1", 32'(rsp_at(1).data), 32'h5678);
        check("b2b_addr2", 32'(rsp_at(2).addr), 32'h43);
        check("b2b_data2", 32'(rsp_at(2).data), 32'h9ABC);
        check("b2b_gap01", rsp_at(1).cyc - rsp_at(0).cyc, 32'd28);
        check("b2b_gap12", rsp_at(2).cyc - rsp_at(1).cyc, 32'd28);

        // Read back the earlier write
        frames.delete();
        rsps.delete();
        send_req(1'b0, 15'h0012, 16'h0000);
        wait_frames(4, "rb_timeout");
        check("rb_rsp_count", 32'(rsps.size()), 32'd1);
        check("rb_rsp_data", 32'(rsp_at(0).data), 32'hBEEF);

        // Reset after HiHi of a read frame
        frames.delete();
        rsps.delete();
        send_req(1'b0, 15'h0041, 16'h0000);
        n = 0;
        while (find_frame(32'h0041_0000) < 0 && n < 2000) begin
            @(negedge iClk);
            n++;
        end
        check("mid_frame_seen", 32'(n < 2000), 32'd1);
        wInternalReset = 1'b1;
        #1;
        check("mid_select", 32'(oBusSelect), 32'd0);
        check("mid_rspvalid", 32'(oRspValid), 32'd0);
        check("mid_ready", 32'(oReqReady), 32'd1);
        repeat (3) @(negedge iClk);
        wInternalReset = 1'b0;
        frames.delete();
        wait_frames(3, "restart_timeout");
        check("mid_no_rsp", 32'(rsps.size()), 32'd0);
        send_req(1'b0, 15'h0041, 16'h0000);
        wait_frames(6, "restart_rd_timeout");
        check("restart_rsp_count", 32'(rsps.size()), 32'd1);
        check("restart_rsp_addr", 32'(rsp_at(0).addr), 32'h41);
        check("restart_rsp_data", 32'(rsp_at(0).data), 32'h1234);

        // Interrupt: 5-cycle pulse appears 2 cycles later for 5 cycles
        @(negedge iClk);
        iBusInterrupt = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge iClk);
            check($sformatf("int_k%0d", k), 32'(oInterrupt), 32'((k >= 2 && k <= 6) ? 1 : 0));
            if (k == 5) iBusInterrupt = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
